// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: field widths, window sizes, decoder states and the token layout.
package lz77_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int SEARCH_SIZE    = 7;
    localparam int LOOKAHEAD_SIZE = 6;
    localparam int OFFSET_W       = 3;
    localparam int LENGTH_W       = 3;
    localparam int FILL_W         = $clog2(SEARCH_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT
    } dec_state_t;

    typedef struct packed {
        logic [OFFSET_W-1:0]   offset;
        logic [LENGTH_W-1:0]   length;
        logic [DATA_WIDTH-1:0] chr;
    } lz77_token_t;

    // Offsets past the end of the window read the oldest byte instead.
    function automatic logic [OFFSET_W-1:0] clamp_offset(input logic [OFFSET_W-1:0] off);
        if (int'(off) > SEARCH_SIZE) begin
            return OFFSET_W'(SEARCH_SIZE);
        end
        return off;
    endfunction

endpackage

// File: rtl/lz77_history.sv
// History shift register of recently emitted bytes (index 0 = newest) with one read port
// that returns the byte at distance d, or at distance d-1 when rd_sel_near is set.
module lz77_history #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 7,
    parameter int DIST_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [WIDTH-1:0]  shift_in,
    input  logic [DIST_W-1:0] rd_dist,
    input  logic              rd_sel_near,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] hist [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (shift_en) begin
            hist[0] <= shift_in;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Distances outside 1..DEPTH (including 0) read as zero rather than indexing out of range.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel_near) begin
                if (int'(rd_dist) == i + 2) begin
                    rd_data = hist[i];
                end
            end else if (int'(rd_dist) == i + 1) begin
                rd_data = hist[i];
            end
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, length, char) tokens into one byte per clock.
// Define LZ77_DEC_CHECK_EN to add the window fill counter and the tok_err illegal-token pulse.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic [OFFSET_W-1:0]   tok_offset,
    input  logic [LENGTH_W-1:0]   tok_length,
    input  logic [DATA_WIDTH-1:0] tok_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef LZ77_DEC_CHECK_EN
    ,
    output logic                  tok_err
`endif
);

    dec_state_t            state;
    lz77_token_t           tok;
    logic [OFFSET_W-1:0]   offset_q;
    logic [LENGTH_W-1:0]   remaining;
    logic [DATA_WIDTH-1:0] char_q;
    logic [OFFSET_W-1:0]   eff_offset;
    logic [OFFSET_W-1:0]   rd_dist;
    logic                  rd_sel_near;
    logic [DATA_WIDTH-1:0] hist_rd;
    logic                  tok_accept;
    logic                  out_fire;
    logic                  is_copy;

    always_comb begin
        tok.offset = tok_offset;
        tok.length = tok_length;
        tok.chr    = tok_char;
    end

    assign tok_ready  = (state == IDLE) && !rst;
    assign tok_accept = tok_valid && tok_ready;
    assign out_fire   = out_valid && out_ready;
    assign eff_offset = clamp_offset(tok.offset);
    assign is_copy    = (tok.length != '0) && (tok.offset != '0);

    // While copying, the byte after the one being handed over sits one slot nearer before the shift.
    assign rd_dist     = (state == IDLE) ? eff_offset : offset_q;
    assign rd_sel_near = (state != IDLE);

    lz77_history #(
        .WIDTH  (DATA_WIDTH),
        .DEPTH  (SEARCH_SIZE),
        .DIST_W (OFFSET_W)
    ) u_history (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (out_fire),
        .shift_in    (out_data),
        .rd_dist     (rd_dist),
        .rd_sel_near (rd_sel_near),
        .rd_data     (hist_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            offset_q  <= '0;
            remaining <= '0;
            char_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tok_accept) begin
                        out_valid <= 1'b1;
                        char_q    <= tok.chr;
                        if (is_copy) begin
                            offset_q  <= eff_offset;
                            remaining <= tok.length;
                            out_data  <= hist_rd;
                            state     <= COPY;
                        end else begin
                            out_data <= tok.chr;
                            state    <= LIT;
                        end
                    end
                end
                COPY: begin
                    if (out_fire) begin
                        remaining <= remaining - LENGTH_W'(1);
                        if (remaining == LENGTH_W'(1)) begin
                            out_data <= char_q;
                            state    <= LIT;
                        end else if (offset_q != OFFSET_W'(1)) begin
                            out_data <= hist_rd;
                        end
                    end
                end
                LIT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef LZ77_DEC_CHECK_EN
    logic [FILL_W-1:0] fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else if (out_fire && (int'(fill) < SEARCH_SIZE)) begin
            fill <= fill + FILL_W'(1);
        end
    end

    always_comb begin
        tok_err = tok_accept &&
                  (((tok.length != '0) && (tok.offset == '0)) ||
                   (int'(tok.offset) > int'(fill)) ||
                   (int'(tok.length) > LOOKAHEAD_SIZE - 1));
    end
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed self-checking bench for lz77_decoder; tok_err checks are built with LZ77_DEC_CHECK_EN.
module tb_lz77_decoder;
    import lz77_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  tok_valid;
    logic                  tok_ready;
    logic [OFFSET_W-1:0]   tok_offset;
    logic [LENGTH_W-1:0]   tok_length;
    logic [DATA_WIDTH-1:0] tok_char;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
`ifdef LZ77_DEC_CHECK_EN
    logic                  tok_err;
    logic                  last_err;
`endif

    int                    compared = 0;
    int                    mismatched = 0;
    int                    busy;
    logic [DATA_WIDTH-1:0] held;
    logic [DATA_WIDTH-1:0] got [$];
    logic [DATA_WIDTH-1:0] exp_chk [7] = '{8'h61, 8'h62, 8'h00, 8'h7a, 8'h6b, 8'h6b, 8'h6d};

    lz77_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_offset (tok_offset),
        .tok_length (tok_length),
        .tok_char   (tok_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef LZ77_DEC_CHECK_EN
        ,
        .tok_err    (tok_err)
`endif
    );

    always #5 clk = ~clk;

    // Record every byte that will be handed over at the coming rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid && out_ready) begin
            got.push_back(out_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStream(input string tag, input string exp);
        checkOutput({tag, "_len"}, 32'(got.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < got.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the token was accepted.
    task automatic applyStimulus(input logic [OFFSET_W-1:0] off, input logic [LENGTH_W-1:0] len,
                                 input logic [DATA_WIDTH-1:0] ch);
        int tries = 0;
        tok_valid  = 1'b1;
        tok_offset = off;
        tok_length = len;
        tok_char   = ch;
        #1;
        while (!tok_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!tok_ready) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL tok_accept: observed tok_ready=0 after %0d cycles expected 1", tries);
            tok_valid = 1'b0;
            return;
        end
`ifdef LZ77_DEC_CHECK_EN
        last_err = tok_err;
`endif
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    task automatic measureBusy(output int n);
        n = 0;
        while (!tok_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle();
        int cycles = 0;
        while ((out_valid || !tok_ready) && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 100) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL wait_idle: observed busy after %0d cycles expected idle", cycles);
        end
    endtask

    task automatic doReset();
        tok_valid = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        rst        = 1'b1;
        tok_valid  = 1'b0;
        tok_offset = '0;
        tok_length = '0;
        tok_char   = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        checkOutput("rst_tok_ready", 32'(tok_ready), 32'(0));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_out_data", 32'(out_data), 32'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_tok_ready", 32'(tok_ready), 32'(1));
        @(negedge clk);

        $display("[TB] literals and back-reference");
        applyStimulus(0, 0, "A");
        measureBusy(busy);
        checkOutput("busy_A", 32'(busy), 32'(1));
        applyStimulus(0, 0, "B");
        measureBusy(busy);
        checkOutput("busy_B", 32'(busy), 32'(1));
        applyStimulus(0, 0, "C");
        measureBusy(busy);
        checkOutput("busy_C", 32'(busy), 32'(1));
        checkStream("abc", "ABC");
        applyStimulus(3, 3, "D");
        measureBusy(busy);
        checkOutput("busy_D", 32'(busy), 32'(4));
        waitIdle();
        checkStream("abcd", "ABCABCD");
        applyStimulus(7, 7, "E");
        waitIdle();
        checkStream("deep", "ABCABCDABCABCDE");

        $display("[TB] overlapping copies");
        doReset();
        applyStimulus(0, 0, "a");
        applyStimulus(1, 5, "x");
        measureBusy(busy);
        checkOutput("busy_run", 32'(busy), 32'(6));
        waitIdle();
        checkStream("run", "aaaaaax");
        doReset();
        applyStimulus(0, 0, "a");
        applyStimulus(0, 0, "b");
        applyStimulus(2, 4, "c");
        waitIdle();
        checkStream("alt", "abababc");

        $display("[TB] back-pressure");
        doReset();
        applyStimulus(0, 0, "p");
        applyStimulus(0, 0, "q");
        applyStimulus(2, 4, "r");
        @(negedge clk);
        out_ready = 1'b0;
        held = out_data;
        checkOutput("bp_first", 32'(held), 32'("q"));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid), 32'(1));
            checkOutput($sformatf("bp_data%0d", i), 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        waitIdle();
        checkStream("bp", "pqpqpqr");

        $display("[TB] reset mid-token");
        doReset();
        applyStimulus(0, 0, "a");
        applyStimulus(1, 5, "x");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("midrst_out_data", 32'(out_data), 32'(0));
        rst = 1'b0;
        #1;
        checkOutput("midrst_tok_ready", 32'(tok_ready), 32'(1));
        got.delete();
        repeat (3) @(negedge clk);
        checkOutput("midrst_silent", 32'(got.size()), 32'(0));
        applyStimulus(1, 2, "q");
        waitIdle();
        checkOutput("midrst_len", 32'(got.size()), 32'(3));
        if (got.size() == 3) begin
            checkOutput("midrst_b0", 32'(got[0]), 32'(0));
            checkOutput("midrst_b1", 32'(got[1]), 32'(0));
            checkOutput("midrst_b2", 32'(got[2]), 32'("q"));
        end

        $display("[TB] shallow history and degenerate tokens");
        doReset();
        applyStimulus(0, 0, "a");
        applyStimulus(0, 0, "b");
        applyStimulus(5, 1, "z");
`ifdef LZ77_DEC_CHECK_EN
        checkOutput("err_deep", 32'(last_err), 32'(1));
        checkOutput("err_deep_pulse", 32'(tok_err), 32'(0));
`endif
        applyStimulus(0, 3, "k");
`ifdef LZ77_DEC_CHECK_EN
        checkOutput("err_degen", 32'(last_err), 32'(1));
`endif
        applyStimulus(1, 1, "m");
`ifdef LZ77_DEC_CHECK_EN
        checkOutput("err_legal", 32'(last_err), 32'(0));
`endif
        waitIdle();
        checkOutput("chk_len", 32'(got.size()), 32'(7));
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checkOutput($sformatf("chk[%0d]", i), 32'(got[i]), 32'(exp_chk[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
LZ77 token decoder; the inverse of match_finder. It consumes (match_offset, match_length, next_char) tokens and reconstructs the original byte stream, one byte per clock under back-pressure. A SEARCH_SIZE-deep history shift register mirrors the encoder's search window. The block sits downstream of the token channel and feeds the byte sink.

Parameters:
DATA_WIDTH, 8, symbol width in bits
SEARCH_SIZE, 7, history depth in bytes; maximum legal offset
LOOKAHEAD_SIZE, 6, encoder lookahead; maximum legal length is LOOKAHEAD_SIZE-1
OFFSET_W, 3, width of the offset field
LENGTH_W, 3, width of the length field

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
tok_valid  input  1  token present
tok_ready  output  1  decoder can accept a token
tok_offset  input  OFFSET_W  distance back into history; 1 = most recently emitted byte
tok_length  input  LENGTH_W  number of bytes to copy (0 = literal only)
tok_char  input  DATA_WIDTH  literal emitted after the copy
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts the byte
out_data  output  DATA_WIDTH  decoded byte
tok_err  output  1  one-cycle pulse on an illegal token (exists only with the optional feature)

Behaviour:
- Reset: synchronous to clk and active-high (rst sampled on posedge clk).
  - Outputs: tok_ready=0 during reset, then 1; out_valid=0, out_data=0, tok_err=0.
  - Internal state: history all zeros; state=IDLE; remaining=0.
- Reset mid-token: the current token is abandoned, all state cleared, and no further bytes are emitted.
- Handshakes: a transfer happens on a cycle where valid&ready are both high.
  - out_data and out_valid are registered; they hold stable while out_valid=1 and out_ready=0.
  - out_valid must not drop without a handshake.
- tok_ready = (state==IDLE) && !rst.
- FSM states: IDLE, COPY, LIT.
  - IDLE, token accepted, tok_length>0: latch offset; remaining=tok_length; latch char. Drive out_data=hist[offset-1], out_valid=1, go to COPY.
  - IDLE, token accepted, tok_length==0: out_data=tok_char, out_valid=1, go to LIT.
  - COPY, each out handshake:
    - Shift out_data into hist[0]; hist[i]<=hist[i-1]; the oldest byte is dropped.
    - Decrement remaining.
    - If remaining was 1: out_data<=latched char, go to LIT.
    - Otherwise: out_data<=post-shift hist[offset-1], i.e. out_data itself when offset==1, else pre-shift hist[offset-2].
  - LIT, out handshake: shift the literal into history, out_valid<=0, go to IDLE.
- Overlapping copies (length >= offset) work naturally: the read distance stays constant while history shifts. Example: offset 1, length 5 replicates the last byte 5 times.
- Latency: first byte is valid the cycle after token acceptance.
- Throughput: one token per length+2 cycles with no back-pressure.
- Width rules: offset and length are unsigned. Offsets greater than SEARCH_SIZE are not encodable at the defaults; when they are encodable, they are clamped to SEARCH_SIZE.
- Degenerate token (tok_length>0, tok_offset==0): treated as literal only, i.e. the copy is skipped and tok_char is emitted.
- Offset deeper than the bytes emitted so far: reads the zero-initialised history.

Optional Feature:
Macro LZ77_DEC_CHECK_EN.
- Defined:
  - Adds a saturating fill counter, range 0..SEARCH_SIZE, incremented per history shift and cleared by rst.
  - tok_err pulses high for exactly one cycle on the acceptance cycle when any of these hold: tok_length>0 and tok_offset==0; tok_offset>fill; tok_length>LOOKAHEAD_SIZE-1.
  - Decoding proceeds exactly as without the feature.
- Not defined: no fill counter, and no tok_err port.

Decomposition:
- Package lz77_pkg holds:
  - DATA_WIDTH, SEARCH_SIZE, LOOKAHEAD_SIZE, OFFSET_W, LENGTH_W;
  - the state enum {IDLE, COPY, LIT};
  - a token struct {offset, length, char} shared with the encoder side.
- One sub-module: lz77_history, the shift register with a parameterised read port selectable at distance d or d-1. The FSM stays in lz77_decoder.

Test Plan:
- Literal tokens (0,0,'A'), (0,0,'B'), (0,0,'C') -> out "ABC"; each token takes 2 cycles; tok_ready low for exactly 1 cycle per token.
- After "ABC", token (3,3,'D') -> out "ABCD"; history newest-first = D,C,B,A,C,B,A.
- After "a", token (1,5,'x') -> out "aaaaax".
  - Also after "ab", token (2,4,'c') -> out "ababc".
- Back-pressure: out_ready held low 3 cycles mid-copy -> out_data and out_valid stable; the byte sequence is unchanged and no byte is duplicated or skipped.
- Reset mid-token: rst asserted during COPY of (1,5,'x') -> next cycle out_valid=0, tok_ready=1, history zero. A following (1,2,'q') -> out 0x00,0x00,'q'.
- With LZ77_DEC_CHECK_EN, after 2 bytes:
  - token (5,1,'z') -> tok_err=1 for one cycle, output still produced;
  - token (0,3,'k') -> tok_err=1, out "k" only.
